// File: rtl/mul_share_arb.sv
// Round-robin sequencer sharing one shift-add multiplier among N_REQ clients.
// Optional watchdog on the multiplier done flag: define MUL_ARB_WDOG_EN.
module mul_share_arb #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 31
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*16-1:0] req_a,
  input  logic [N_REQ*8-1:0]  req_b,
  output logic [N_REQ-1:0]    req_ready,
  output logic                rsp_valid,
  output logic [ID_W-1:0]     rsp_id,
  output logic [15:0]         rsp_data,
  output logic                rsp_err,
  output logic                mul_start,
  output logic [15:0]         mul_a,
  output logic [7:0]          mul_b,
  input  logic [15:0]         mul_p,
  input  logic                mul_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [15:0]     rsp_data_q, rsp_data_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            mul_start_q, mul_start_d;
  logic [15:0]     mul_a_q, mul_a_d;
  logic [7:0]      mul_b_q, mul_b_d;
  logic [ID_W-1:0] grant;
  logic            grant_vld;

`ifdef MUL_ARB_WDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic             rsp_err_q, rsp_err_d;
`endif

  // Scan downwards so the client closest after ptr overwrites the others.
  always_comb begin
    grant     = ptr_q;
    grant_vld = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      int idx;
      idx = (int'(ptr_q) + k) % N_REQ;
      if (req_valid[idx]) begin
        grant     = ID_W'(idx);
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && grant_vld) req_ready[grant] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    mul_start_d = 1'b0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
`ifdef MUL_ARB_WDOG_EN
    wdog_cnt_d  = wdog_cnt_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          mul_a_d     = req_a[16*grant +: 16];
          mul_b_d     = req_b[8*grant +: 8];
          id_d        = grant;
          ptr_d       = grant;
          mul_start_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      // A stale done from the previous product is still high here.
      ISSUE: begin
        state_d = WAIT;
`ifdef MUL_ARB_WDOG_EN
        wdog_cnt_d = '0;
`endif
      end
      WAIT: begin
        if (mul_done) begin
          rsp_data_d  = mul_p;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
`ifdef MUL_ARB_WDOG_EN
          rsp_err_d   = 1'b0;
        end else if (wdog_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          wdog_cnt_d  = wdog_cnt_q + 1'b1;
`endif
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= ID_W'(N_REQ - 1);
      id_q        <= '0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
`ifdef MUL_ARB_WDOG_EN
      wdog_cnt_q  <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      mul_start_q <= mul_start_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
`ifdef MUL_ARB_WDOG_EN
      wdog_cnt_q  <= wdog_cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
`ifdef MUL_ARB_WDOG_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mul_share_arb.sv
// Scoreboard bench for mul_share_arb with a behavioural 8-step multiplier.
// Honours MUL_ARB_WDOG_EN to pick the expected watchdog behaviour.
module tb_mul_share_arb;
  localparam int N_REQ   = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 31;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [N_REQ-1:0]    req_valid = '0;
  logic [N_REQ*16-1:0] req_a = '0;
  logic [N_REQ*8-1:0]  req_b = '0;
  logic [N_REQ-1:0]    req_ready;
  logic                rsp_valid;
  logic [ID_W-1:0]     rsp_id;
  logic [15:0]         rsp_data;
  logic                rsp_err;
  logic                mul_start;
  logic [15:0]         mul_a;
  logic [7:0]          mul_b;
  logic [15:0]         mul_p;
  logic                mul_done;

  mul_share_arb #(.N_REQ(N_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .mul_start(mul_start),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .mul_done(mul_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          rsp_ids[$];
  int          compared = 0;
  int          mismatched = 0;
  int          cycle = 0;
  int          rsp_seen = 0;
  int          last_grant = N_REQ - 1;
  int          next_idle = 0;
  bit          force_done_low = 1'b0;
  bit          rand_en = 1'b0;
  logic [N_REQ-1:0] pend = '0;
  logic [N_REQ-1:0] hold_mask = '0;
  logic [N_REQ-1:0] granted_mask = '0;
  logic [15:0] op_a [N_REQ];
  logic [7:0]  op_b [N_REQ];
  logic [15:0] last_data = '0;
  logic [ID_W-1:0] last_id = '0;

  // Stand-in multiplier: start captures operands, eight add/shift steps, done stays high.
  logic [15:0] m_cand, m_acc;
  logic [7:0]  m_plier;
  int          m_cnt;
  logic        m_done;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cand <= '0; m_acc <= '0; m_plier <= '0; m_cnt <= 0; m_done <= 1'b0;
    end else if (mul_start) begin
      m_cand <= mul_a; m_plier <= mul_b; m_acc <= '0; m_cnt <= 8; m_done <= 1'b0;
    end else if (m_cnt != 0) begin
      if (m_plier[0]) m_acc <= m_acc + m_cand;
      m_cand  <= m_cand << 1;
      m_plier <= m_plier >> 1;
      m_cnt   <= m_cnt - 1;
      if (m_cnt == 1) m_done <= 1'b1;
    end
  end
  assign mul_p    = m_acc;
  assign mul_done = m_done & ~force_done_low;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic void check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endfunction

  function automatic int rr_pick(input logic [N_REQ-1:0] v, input int last);
    for (int k = 1; k <= N_REQ; k++) begin
      int idx;
      idx = (last + k) % N_REQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  int               mon_g;
  logic [N_REQ-1:0] mon_exp;
  exp_t             mon_e;
  logic [31:0]      mon_full;

  // Monitor: pops the scoreboard on every strobe and predicts the grant each cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid) begin
        rsp_seen++;
        if (sb.size() == 0) begin
          check_output("rsp_unexpected", sb.size(), 1);
        end else begin
          mon_e = sb.pop_front();
          check_output("rsp_id", rsp_id, mon_e.id);
          check_output("rsp_data", rsp_data, mon_e.data);
          check_output("rsp_err", rsp_err, mon_e.err);
          check_output("rsp_latency", cycle, mon_e.due);
        end
        rsp_ids.push_back(int'(rsp_id));
        last_id   = rsp_id;
        last_data = rsp_data;
      end else begin
        check_output("rsp_hold_id", rsp_id, last_id);
        check_output("rsp_hold_data", rsp_data, last_data);
      end
      if ((mul_start || m_cnt != 0) && sb.size() != 0) begin
        check_output("mul_a_hold", mul_a, sb[0].a);
        check_output("mul_b_hold", mul_b, sb[0].b);
      end
      mon_exp = '0;
      mon_g   = -1;
      if (cycle >= next_idle) begin
        mon_g = rr_pick(req_valid, last_grant);
        if (mon_g >= 0) mon_exp[mon_g] = 1'b1;
      end
      check_output("req_ready", req_ready, mon_exp);
      if (mon_g >= 0) begin
        mon_e.id = mon_g;
        mon_e.a  = req_a[16*mon_g +: 16];
        mon_e.b  = req_b[8*mon_g +: 8];
        mon_full = 32'(mon_e.a) * 32'(mon_e.b);
        if (!force_done_low) begin
          mon_e.data = mon_full[15:0];
          mon_e.err  = 1'b0;
          mon_e.due  = cycle + 11;
          sb.push_back(mon_e);
          next_idle = mon_e.due + 1;
        end else begin
`ifdef MUL_ARB_WDOG_EN
          mon_e.data = '0;
          mon_e.err  = 1'b1;
          mon_e.due  = cycle + 2 + TIMEOUT;
          sb.push_back(mon_e);
          next_idle = mon_e.due + 1;
`else
          next_idle = 32'h7fff_ffff;
`endif
        end
        last_grant = mon_g;
        granted_mask[mon_g] = 1'b1;
      end
    end
  end

  task automatic arm(input int i, input logic [15:0] a, input logic [7:0] b);
    pend[i] = 1'b1;
    op_a[i] = a;
    op_b[i] = b;
  endtask

  task automatic apply_stimulus();
    @(posedge clk);
    #2;
    pend = pend & ~granted_mask;
    granted_mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (rand_en && pend[i] && $urandom_range(15) == 0) pend[i] = 1'b0;
      if (!pend[i]) begin
        op_a[i] = 16'($urandom);
        op_b[i] = 8'($urandom);
        if (hold_mask[i] || (rand_en && $urandom_range(7) == 0)) pend[i] = 1'b1;
      end
      req_valid[i]       = pend[i];
      req_a[16*i +: 16]  = op_a[i];
      req_b[8*i +: 8]    = op_b[i];
    end
  endtask

  task automatic wait_quiet(input int budget, input string name);
    int  n;
    bit  quiet;
    n = 0;
    quiet = (pend == '0 && sb.size() == 0 && cycle >= next_idle);
    while (!quiet && n < budget) begin
      apply_stimulus();
      n++;
      quiet = (pend == '0 && sb.size() == 0 && cycle >= next_idle);
    end
    check_output({name, "_done_in_budget"}, quiet, 1);
  endtask

  task automatic wait_grant(input int i, input string name);
    int n;
    n = 0;
    while (pend[i] && n < 40) begin
      apply_stimulus();
      n++;
    end
    check_output({name, "_granted"}, pend[i], 0);
  endtask

  // Asserts rst at the current time and releases it two clock edges later.
  task automatic reset_now();
    rst = 1'b1;
    pend = '0;
    granted_mask = '0;
    req_valid = '0;
    sb.delete();
    #1;
    check_output("rst_rsp_valid", rsp_valid, 0);
    check_output("rst_rsp_id", rsp_id, 0);
    check_output("rst_rsp_data", rsp_data, 0);
    check_output("rst_rsp_err", rsp_err, 0);
    check_output("rst_mul_start", mul_start, 0);
    check_output("rst_mul_a", mul_a, 0);
    check_output("rst_mul_b", mul_b, 0);
    check_output("rst_req_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    #3;
    last_grant = N_REQ - 1;
    next_idle  = 0;
    last_id    = '0;
    last_data  = '0;
    rst = 1'b0;
  endtask

  int base;
  int seen0;
  int threes;
  int exp_order [4] = '{0, 1, 2, 3};

  initial begin
    for (int i = 0; i < N_REQ; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    #3;
    reset_now();

    $display("[TB] all four clients together");
    base = rsp_ids.size();
    for (int i = 0; i < N_REQ; i++) arm(i, 16'(i + 1), 8'd10);
    wait_quiet(80, "all_four");
    check_output("all_four_count", rsp_ids.size() - base, 4);
    for (int k = 0; k < 4 && base + k < rsp_ids.size(); k++)
      check_output("all_four_order", rsp_ids[base + k], exp_order[k]);

    $display("[TB] single request client 0");
    arm(0, 16'd3, 8'd5);
    wait_quiet(40, "single");

    $display("[TB] fairness between clients 1 and 3");
    base = rsp_ids.size();
    hold_mask = 4'b1010;
    arm(1, 16'($urandom), 8'($urandom));
    arm(3, 16'($urandom), 8'($urandom));
    repeat (76) apply_stimulus();
    hold_mask = '0;
    wait_quiet(60, "fair");
    threes = 0;
    for (int k = base; k < rsp_ids.size(); k++) begin
      if (rsp_ids[k] == 3) threes++;
      if (k > base) check_output("fair_alternate", rsp_ids[k] != rsp_ids[k-1], 1);
    end
    check_output("fair_client3_served", threes >= 3, 1);

    $display("[TB] overflow truncation");
    arm(2, 16'hFFFF, 8'hFF);
    wait_quiet(40, "overflow");

    $display("[TB] reset four cycles into WAIT");
    seen0 = rsp_seen;
    arm(0, 16'h1234, 8'h56);
    wait_grant(0, "rst_mid");
    repeat (5) @(posedge clk);
    #3;
    reset_now();
    repeat (3) apply_stimulus();
    check_output("rst_mid_no_rsp", rsp_seen - seen0, 0);
    base = rsp_ids.size();
    arm(0, 16'd7, 8'd9);
    arm(1, 16'd2, 8'd2);
    arm(3, 16'd4, 8'd4);
    wait_quiet(60, "after_rst");
    if (rsp_ids.size() > base) check_output("after_rst_first_id", rsp_ids[base], 0);
    else check_output("after_rst_first_id", rsp_ids.size(), base + 1);

    $display("[TB] multiplier done stuck low");
    force_done_low = 1'b1;
    seen0 = rsp_seen;
    arm(2, 16'h0101, 8'h03);
`ifdef MUL_ARB_WDOG_EN
    wait_quiet(TIMEOUT + 40, "wdog");
    check_output("wdog_rsp_count", rsp_seen - seen0, 1);
    force_done_low = 1'b0;
`else
    wait_grant(2, "stuck");
    repeat (60) apply_stimulus();
    check_output("stuck_no_rsp", rsp_seen - seen0, 0);
    check_output("stuck_rsp_err", rsp_err, 0);
    force_done_low = 1'b0;
    #1;
    reset_now();
`endif

    $display("[TB] randomized traffic");
    rand_en = 1'b1;
    repeat (800) apply_stimulus();
    rand_en = 1'b0;
    for (int i = 0; i < N_REQ; i++) pend[i] = 1'b0;
    wait_quiet(60, "random");
    check_output("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
